// File: rtl/brick_ram_arbiter_pkg.sv
// Shared constants, FSM state type and the level initialisation rule for the
// 64 x 2-bit brick RAM.
package brick_pkg;

    localparam int N_BRICKS = 64;
    localparam int HITS_W   = 2;
    localparam int ADDR_W   = 6;
    localparam int CNT_W    = 7;
    localparam int LEVEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HIT_RD   = 3'd1,
        ST_HIT_WAIT = 3'd2,
        ST_HIT_WR   = 3'd3,
        ST_LOAD     = 3'd4
    } arb_state_t;

    // Hits for brick addr in a fresh level: always 1..3, so every level starts full.
    function automatic logic [HITS_W-1:0] brick_init(input logic [LEVEL_W-1:0] level,
                                                     input logic [ADDR_W-1:0]  addr);
        logic [3:0] sum_v;
        logic [1:0] mod_v;
        sum_v = {1'b0, addr[5:3]} + {1'b0, level};
        mod_v = 2'(sum_v % 4'd3);
        return mod_v + 2'd1;
    endfunction

endpackage

// File: rtl/brick_ram_arbiter_port_mux.sv
// Fixed-priority RAM port grant (render read over FSM access) and the
// registered tags that identify who owns the data returning next cycle.
module brick_port_mux
    import brick_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              fsm_req,
    input  logic              fsm_we,
    input  logic [ADDR_W-1:0] fsm_addr,
    input  logic [HITS_W-1:0] fsm_wdata,
    output logic              fsm_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [HITS_W-1:0] ram_wdata,
    output logic              rd_pend_r,
    output logic              fsm_pend_r
);

    // Port grant: render reads always win, the FSM retries next cycle.
    always_comb begin
        fsm_gnt   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rd_req) begin
            ram_addr = rd_addr;
        end else if (fsm_req) begin
            fsm_gnt   = 1'b1;
            ram_addr  = fsm_addr;
            ram_we    = fsm_we;
            ram_wdata = fsm_wdata;
        end else begin
            fsm_gnt = 1'b0;
        end
    end

    // Return tags for the one-cycle RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r  <= 1'b0;
            fsm_pend_r <= 1'b0;
        end else begin
            rd_pend_r  <= rd_req;
            fsm_pend_r <= fsm_gnt & ~fsm_we;
        end
    end

endmodule

// File: rtl/brick_ram_arbiter.sv
// Brick RAM owner: shares the single port between render reads, collision
// read-modify-write decrements and the level loader; tracks live bricks.
module brick_ram_arbiter
    import brick_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic [LEVEL_W-1:0] load_level,
    output logic               load_busy,
    output logic               load_done,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [HITS_W-1:0]  rd_data,
    input  logic               hit_req,
    input  logic [ADDR_W-1:0]  hit_addr,
    output logic               hit_ack,
    output logic [HITS_W-1:0]  hit_old,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [HITS_W-1:0]  ram_wdata,
    input  logic [HITS_W-1:0]  ram_rdata,
    output logic [CNT_W-1:0]   bricks_left,
    output logic               cleared
);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [ADDR_W-1:0]   k_r;
    logic [LEVEL_W-1:0]  level_r;
    logic [HITS_W-1:0]   old_r;
    logic                load_pend_r;
    logic                loaded_r;
    logic [CNT_W-1:0]    bricks_left_r;
    logic                cleared_r;
    logic                load_done_r;
    logic [CNT_W-1:0]    bricks_nxt_s;
    logic                loaded_nxt_s;
    logic                fsm_req_s;
    logic                fsm_we_s;
    logic [ADDR_W-1:0]   fsm_addr_s;
    logic [HITS_W-1:0]   fsm_wdata_s;
    logic                fsm_gnt_s;
    logic                rd_pend_r;
    logic                fsm_pend_r;
    logic                hit_ack_s;
    logic                load_last_s;

    brick_port_mux u_port_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .fsm_req    (fsm_req_s),
        .fsm_we     (fsm_we_s),
        .fsm_addr   (fsm_addr_s),
        .fsm_wdata  (fsm_wdata_s),
        .fsm_gnt    (fsm_gnt_s),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .rd_pend_r  (rd_pend_r),
        .fsm_pend_r (fsm_pend_r)
    );

    // An empty brick acks without touching the port; a restart in the same cycle cancels completion.
    assign hit_ack_s   = (state_r == ST_HIT_WR) && ((old_r == 2'd0) || fsm_gnt_s);
    assign load_last_s = (state_r == ST_LOAD) && fsm_gnt_s && !load_req &&
                         (k_r == 6'(N_BRICKS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a pending load outranks a waiting hit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_req || load_pend_r) begin
                    state_nxt_s = ST_LOAD;
                end else if (hit_req) begin
                    state_nxt_s = ST_HIT_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HIT_RD:   state_nxt_s = fsm_gnt_s ? ST_HIT_WAIT : ST_HIT_RD;
            ST_HIT_WAIT: state_nxt_s = fsm_pend_r ? ST_HIT_WR : ST_HIT_WAIT;
            ST_HIT_WR:   state_nxt_s = hit_ack_s ? ST_IDLE : ST_HIT_WR;
            ST_LOAD:     state_nxt_s = load_last_s ? ST_IDLE : ST_LOAD;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM port request per state.
    always_comb begin
        fsm_req_s   = 1'b0;
        fsm_we_s    = 1'b0;
        fsm_addr_s  = '0;
        fsm_wdata_s = '0;
        case (state_r)
            ST_HIT_RD: begin
                fsm_req_s  = 1'b1;
                fsm_addr_s = hit_addr;
            end
            ST_HIT_WR: begin
                if (old_r != 2'd0) begin
                    fsm_req_s   = 1'b1;
                    fsm_we_s    = 1'b1;
                    fsm_addr_s  = hit_addr;
                    fsm_wdata_s = old_r - 2'd1;
                end else begin
                    fsm_req_s = 1'b0;
                end
            end
            ST_LOAD: begin
                fsm_req_s   = 1'b1;
                fsm_we_s    = 1'b1;
                fsm_addr_s  = k_r;
                fsm_wdata_s = brick_init(level_r, k_r);
            end
            default: fsm_req_s = 1'b0;
        endcase
    end

    // Live-brick count and loaded flag for the coming cycle.
    always_comb begin
        bricks_nxt_s = bricks_left_r;
        loaded_nxt_s = loaded_r;
        if (load_last_s) begin
            bricks_nxt_s = 7'(N_BRICKS);
            loaded_nxt_s = 1'b1;
        end else if (hit_ack_s && (old_r == 2'd1) && (bricks_left_r != 7'd0)) begin
            bricks_nxt_s = bricks_left_r - 7'd1;
        end else begin
            bricks_nxt_s = bricks_left_r;
        end
    end

    // Datapath registers: load counter, latched load request, captured old value, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r           <= '0;
            level_r       <= '0;
            old_r         <= '0;
            load_pend_r   <= 1'b0;
            loaded_r      <= 1'b0;
            bricks_left_r <= '0;
            cleared_r     <= 1'b0;
            load_done_r   <= 1'b0;
        end else begin
            if (load_req) begin
                level_r <= load_level;
            end
            if (state_r == ST_LOAD) begin
                if (load_req) begin
                    k_r <= '0;
                end else if (fsm_gnt_s) begin
                    k_r <= k_r + 6'd1;
                end
            end else begin
                k_r <= '0;
            end
            if ((state_r == ST_IDLE) || (state_r == ST_LOAD)) begin
                load_pend_r <= 1'b0;
            end else if (load_req) begin
                load_pend_r <= 1'b1;
            end
            if ((state_r == ST_HIT_WAIT) && fsm_pend_r) begin
                old_r <= ram_rdata;
            end
            loaded_r      <= loaded_nxt_s;
            bricks_left_r <= bricks_nxt_s;
            load_done_r   <= load_last_s;
            cleared_r     <= (bricks_nxt_s == 7'd0) && loaded_nxt_s && (state_nxt_s != ST_LOAD);
        end
    end

    assign load_busy   = (state_r == ST_LOAD);
    assign load_done   = load_done_r;
    assign rd_valid    = rd_pend_r;
    assign rd_data     = rd_pend_r ? ram_rdata : 2'd0;
    assign hit_ack     = hit_ack_s;
    assign hit_old     = hit_ack_s ? old_r : 2'd0;
    assign bricks_left = bricks_left_r;
    assign cleared     = cleared_r;

endmodule

// File: tb/tb_brick_ram_arbiter.sv
// Scoreboard bench for brick_ram_arbiter with a behavioural synchronous RAM.
module tb_brick_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic [2:0] load_level;
    logic       load_busy;
    logic       load_done;
    logic       rd_req;
    logic [5:0] rd_addr;
    logic       rd_valid;
    logic [1:0] rd_data;
    logic       hit_req;
    logic [5:0] hit_addr;
    logic       hit_ack;
    logic [1:0] hit_old;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;
    logic [6:0] bricks_left;
    logic       cleared;
    logic [24:0] outs;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  data;
    } rd_t;

    rd_t        rd_q[$];
    logic [1:0] hit_q[$];
    logic [7:0] wr_q[$];
    rd_t        mon_rd;
    logic [7:0] mon_wr;
    logic [1:0] mon_hit;

    logic [1:0] ram_mem [64];
    logic [1:0] exp_mem [64];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit wr_chk_en = 1'b1;
    logic clr_at_ack;
    int hit_lat;
    int rd_list[5] = '{40, 48, 56, 41, 63};

    brick_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .load_level  (load_level),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .hit_req     (hit_req),
        .hit_addr    (hit_addr),
        .hit_ack     (hit_ack),
        .hit_old     (hit_old),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .bricks_left (bricks_left),
        .cleared     (cleared)
    );

    assign outs = {load_busy, load_done, rd_valid, rd_data, hit_ack, hit_old,
                   ram_addr, ram_we, ram_wdata, bricks_left, cleared};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_init(input int lvl, input int k);
        return 2'(1 + (((k / 8) + lvl) % 3));
    endfunction

    function automatic int count_live();
        int n = 0;
        for (int i = 0; i < 64; i++) if (exp_mem[i] != 2'd0) n++;
        return n;
    endfunction

    task automatic set_level(input int lvl);
        for (int i = 0; i < 64; i++) exp_mem[i] = exp_init(lvl, i);
    endtask

    task automatic do_load(input int lvl, input bit push, output int c_start);
        if (push) begin
            for (int k = 0; k < 64; k++) wr_q.push_back({6'(k), exp_init(lvl, k)});
        end
        load_req   = 1'b1;
        load_level = 3'(lvl);
        c_start    = cyc;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int lim = cyc + budget;
        while (!load_done && cyc < lim) step();
    endtask

    task automatic do_hit(input int a);
        logic [1:0] e;
        e = exp_mem[a];
        hit_q.push_back(e);
        if (e != 2'd0) begin
            wr_q.push_back({6'(a), e - 2'd1});
            exp_mem[a] = e - 2'd1;
        end
        hit_req  = 1'b1;
        hit_addr = 6'(a);
        hit_lat  = 1;
        while (!hit_ack && hit_lat < 40) begin
            step();
            hit_lat++;
        end
        check("hit_ack_seen", hit_ack, 1);
        clr_at_ack = cleared;
        step();
        hit_req = 1'b0;
    endtask

    // Output monitor: pops scoreboard queues as the DUT produces results.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                rd_cnt++;
                check("rd_expected", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    mon_rd = rd_q.pop_front();
                    check("rd_data", rd_data, mon_rd.data);
                    check("rd_latency", cyc - mon_rd.cyc, 1);
                end
            end
            if (hit_ack) begin
                check("hit_expected", hit_q.size() > 0, 1);
                if (hit_q.size() > 0) begin
                    mon_hit = hit_q.pop_front();
                    check("hit_old", hit_old, mon_hit);
                end
            end
            if (ram_we) begin
                wr_cnt++;
                if (wr_chk_en) begin
                    check("wr_expected", wr_q.size() > 0, 1);
                    if (wr_q.size() > 0) begin
                        mon_wr = wr_q.pop_front();
                        check("wr_addr", ram_addr, mon_wr[7:2]);
                        check("wr_data", ram_wdata, mon_wr[1:0]);
                    end
                end
            end
            if (load_done) done_cnt++;
        end
    end

    initial begin
        int c0, c1, d0, w0, r0, n;
        rst_n = 1'b0; load_req = 1'b0; load_level = 3'd0;
        rd_req = 1'b0; rd_addr = 6'd0; hit_req = 1'b0; hit_addr = 6'd0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 2'd0;
        #2;
        check("reset_outs", outs, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_outs", outs, 0);

        // Load level 2 with no contention.
        d0 = done_cnt; w0 = wr_cnt;
        do_load(2, 1'b1, c0);
        wait_done(100);
        check("load_latency", cyc - c0, 65);
        check("load_bricks", bricks_left, 64);
        check("load_cleared", cleared, 0);
        step(); step();
        check("load_done_once", done_cnt - d0, 1);
        check("load_writes", wr_cnt - w0, 64);
        set_level(2);

        // Render reads steal five cycles from a level 0 load.
        r0 = rd_cnt;
        do_load(0, 1'b1, c0);
        repeat (5) step();
        check("busy_in_load", load_busy, 1);
        for (int i = 0; i < 5; i++) begin
            rd_req  = 1'b1;
            rd_addr = 6'(rd_list[i]);
            rd_q.push_back('{cyc: 32'(cyc), data: exp_mem[rd_list[i]]});
            step();
        end
        rd_req = 1'b0;
        wait_done(100);
        check("load_stall_latency", cyc - c0, 70);
        step();
        check("rd_count", rd_cnt - r0, 5);
        set_level(0);

        // Decrement entry 10 (=2) twice.
        do_hit(10);
        check("hit_lat_a", hit_lat, 4);
        check("bricks_after_hit_a", bricks_left, count_live());
        do_hit(10);
        check("hit_lat_b", hit_lat, 4);
        check("bricks_after_hit_b", bricks_left, count_live());

        // Entry 5 (=1) to zero, then a hit on the empty brick.
        do_hit(5);
        w0 = wr_cnt;
        do_hit(5);
        check("empty_no_write", wr_cnt - w0, 0);
        check("bricks_after_empty", bricks_left, count_live());

        // load_req arrives while the hit is in HIT_WAIT.
        hit_q.push_back(exp_mem[11]);
        wr_q.push_back({6'd11, exp_mem[11] - 2'd1});
        hit_req = 1'b1; hit_addr = 6'd11;
        step(); step();
        for (int k = 0; k < 64; k++) wr_q.push_back({6'(k), exp_init(2, k)});
        load_req = 1'b1; load_level = 3'd2; c1 = cyc;
        step();
        load_req = 1'b0;
        check("ack_before_load", hit_ack, 1);
        check("busy_at_ack", load_busy, 0);
        step();
        hit_req = 1'b0;
        wait_done(100);
        check("latched_load_latency", cyc - c1, 67);
        step();
        set_level(2);
        check("bricks_latched_load", bricks_left, count_live());

        // Hit request raised mid-load waits for load_done.
        do_load(1, 1'b1, c0);
        repeat (3) step();
        d0 = done_cnt;
        hit_q.push_back(exp_init(1, 20));
        wr_q.push_back({6'd20, exp_init(1, 20) - 2'd1});
        hit_req = 1'b1; hit_addr = 6'd20;
        n = 0;
        while (!hit_ack && n < 200) begin
            step();
            n++;
        end
        check("hit_during_load_ack", hit_ack, 1);
        check("hit_after_done", done_cnt - d0, 1);
        check("idle_at_hit_ack", load_busy, 0);
        step();
        hit_req = 1'b0;
        set_level(1);
        exp_mem[20] = exp_init(1, 20) - 2'd1;
        check("bricks_hit_after_load", bricks_left, count_live());

        // Restart: second load_req while k=30 is on the port.
        wr_chk_en = 1'b0;
        d0 = done_cnt;
        do_load(0, 1'b0, c0);
        while (cyc < c0 + 31) step();
        load_req = 1'b1; load_level = 3'd2; c1 = cyc;
        step();
        load_req = 1'b0;
        wait_done(100);
        check("restart_latency", cyc - c1, 65);
        step();
        check("restart_done_once", done_cnt - d0, 1);
        wr_chk_en = 1'b1;
        set_level(2);
        for (int i = 0; i < 5; i++) begin
            rd_req  = 1'b1;
            rd_addr = 6'(i * 13 + 3);
            rd_q.push_back('{cyc: 32'(cyc), data: exp_mem[i * 13 + 3]});
            step();
        end
        rd_req = 1'b0;
        step();

        // Win: load level 0 and knock out every brick.
        do_load(0, 1'b1, c0);
        wait_done(100);
        step();
        set_level(0);
        for (int a = 0; a < 64; a++) begin
            while (exp_mem[a] != 2'd0) do_hit(a);
        end
        check("win_cleared_at_ack", clr_at_ack, 0);
        check("win_bricks", bricks_left, 0);
        check("win_cleared", cleared, 1);
        step(); step();
        check("hit_q_empty", hit_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);

        // Reset in the middle of a hit RMW.
        do_load(1, 1'b1, c0);
        wait_done(100);
        step();
        hit_req = 1'b1; hit_addr = 6'd3;
        step(); step();
        check("pre_reset_bricks", bricks_left, 64);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs, 0);
        hit_req = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        check("post_reset_outs", outs, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
